// File: rtl/ones_pkg.sv
// ============================================================================
//  Module      : ones_pkg
//  Description : Shared types and constants for the ones-count frame
//                accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ones_pkg;

    localparam int COUNT_W   = 6;
    localparam int MAX_WORDS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : ones_pkg

`default_nettype wire

// File: rtl/ones_accumulator.sv
// ============================================================================
//  Module      : ones_accumulator
//  Description : Sums per-word ones counts over a frame closed by in_last or
//                by MAX_WORDS beats; holds the result until out_ready.
//                Optional macro ONES_ACC_THRESH_EN adds THRESH / out_above.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ones_accumulator
    import ones_pkg::*;
#(
`ifdef ONES_ACC_THRESH_EN
    parameter int unsigned THRESH    = 2016,
`endif
    parameter int          MAX_WORDS = ones_pkg::MAX_WORDS,
    localparam int         TOTAL_W   = $clog2(63 * MAX_WORDS + 1),
    localparam int         WORDS_W   = $clog2(MAX_WORDS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [COUNT_W-1:0] in_count,
    input  logic               in_last,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] out_total,
    output logic [WORDS_W-1:0] out_words,
`ifdef ONES_ACC_THRESH_EN
    output logic               out_above,
`endif
    output logic               out_trunc
);

    localparam logic [WORDS_W-1:0] c_max_words = WORDS_W'(MAX_WORDS);
    localparam logic [WORDS_W-1:0] c_one_word  = WORDS_W'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [TOTAL_W-1:0]   r_acc;
    logic [TOTAL_W-1:0]   w_acc_next;
    logic [WORDS_W-1:0]   r_words;
    logic [WORDS_W-1:0]   w_words_next;
    logic                 r_trunc;
    logic                 w_trunc_next;

    logic                 w_accept;
    logic [TOTAL_W-1:0]   w_count_ext;
    logic [WORDS_W-1:0]   w_words_inc;
    logic                 w_at_max;

    assign in_ready    = (r_state != DONE);
    assign w_accept    = in_valid && in_ready;
    assign w_count_ext = TOTAL_W'(in_count);
    assign w_words_inc = r_words + c_one_word;
    assign w_at_max    = (w_words_inc == c_max_words);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_words <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_words <= w_words_next;
            r_trunc <= w_trunc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_words_next = r_words;
        w_trunc_next = r_trunc;
        case (r_state)
            IDLE: begin
                // MAX_WORDS >= 2, so a single opening beat can never truncate
                if (w_accept) begin
                    w_acc_next   = w_count_ext;
                    w_words_next = c_one_word;
                    w_trunc_next = 1'b0;
                    w_state_next = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_accept) begin
                    w_acc_next   = r_acc + w_count_ext;
                    w_words_next = w_words_inc;
                    w_trunc_next = w_at_max && !in_last;
                    if (in_last || w_at_max) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_acc_next   = '0;
                    w_words_next = '0;
                    w_trunc_next = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_acc_next   = '0;
                w_words_next = '0;
                w_trunc_next = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    assign out_valid = (r_state == DONE);
    assign out_total = r_acc;
    assign out_words = r_words;
    assign out_trunc = r_trunc;

`ifdef ONES_ACC_THRESH_EN
    assign out_above = out_valid && (32'(r_acc) >= THRESH);
`endif

endmodule : ones_accumulator

`default_nettype wire

// File: tb/tb_ones_accumulator.sv
// ============================================================================
//  Module      : tb_ones_accumulator
//  Description : Directed self-checking bench for ones_accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ones_accumulator;

    localparam int TOTAL_W = 12;
    localparam int WORDS_W = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [5:0]         in_count = '0;
    logic               in_last = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [TOTAL_W-1:0] out_total;
    logic [WORDS_W-1:0] out_words;
    logic               out_trunc;
`ifdef ONES_ACC_THRESH_EN
    logic               out_above;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ones_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_words (out_words),
`ifdef ONES_ACC_THRESH_EN
        .out_above (out_above),
`endif
        .out_trunc (out_trunc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int cnt, input bit last);
        in_valid = 1'b1;
        in_count = 6'(cnt);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic frame(input int n, input int cnt, input bit last_on_final);
        for (int i = 0; i < n; i++) beat(cnt, last_on_final && (i == n - 1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_total", 32'(out_total), 0);
        check("rst_words", 32'(out_words), 0);
        check("rst_trunc", 32'(out_trunc), 0);

        // single beat, latency 1
        beat(63, 1'b1);
        check("single_valid", 32'(out_valid), 1);
        check("single_total", 32'(out_total), 63);
        check("single_words", 32'(out_words), 1);
        check("single_trunc", 32'(out_trunc), 0);
        check("single_ready", 32'(in_ready), 0);
        drain();
        check("drain_valid", 32'(out_valid), 0);
        check("drain_total", 32'(out_total), 0);

        // three beats, held under backpressure with in_valid asserted
        beat(10, 1'b0);
        beat(20, 1'b0);
        check("run_total", 32'(out_total), 30);
        check("run_words", 32'(out_words), 2);
        check("run_valid", 32'(out_valid), 0);
        beat(33, 1'b1);
        in_valid = 1'b1;
        in_count = 6'd5;
        for (int i = 0; i < 4; i++) begin
            check("hold_total", 32'(out_total), 63);
            check("hold_words", 32'(out_words), 3);
            check("hold_ready", 32'(in_ready), 0);
            check("hold_valid", 32'(out_valid), 1);
            step();
        end
        // beat still offered during the release cycle must not be taken
        drain();
        in_valid = 1'b0;
        check("rel_total", 32'(out_total), 0);
        check("rel_words", 32'(out_words), 0);
        check("rel_ready", 32'(in_ready), 1);

        // truncation at MAX_WORDS
        frame(63, 63, 1'b0);
        check("w63_valid", 32'(out_valid), 0);
        check("w63_words", 32'(out_words), 63);
        beat(63, 1'b0);
        check("trunc_valid", 32'(out_valid), 1);
        check("trunc_total", 32'(out_total), 4032);
        check("trunc_words", 32'(out_words), 64);
        check("trunc_flag", 32'(out_trunc), 1);
        drain();
        check("trunc_clear", 32'(out_trunc), 0);
        frame(64, 63, 1'b1);
        check("last64_total", 32'(out_total), 4032);
        check("last64_words", 32'(out_words), 64);
        check("last64_trunc", 32'(out_trunc), 0);
        drain();

        // gaps with garbage while invalid
        beat(5, 1'b0);
        in_count = 6'd63;
        in_last  = 1'b1;
        repeat (3) step();
        check("gap_total", 32'(out_total), 5);
        check("gap_valid", 32'(out_valid), 0);
        beat(7, 1'b1);
        check("gap_final", 32'(out_total), 12);
        check("gap_words", 32'(out_words), 2);
        drain();

        // asynchronous reset mid-frame
        beat(40, 1'b0);
        beat(50, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_total", 32'(out_total), 0);
        check("arst_words", 32'(out_words), 0);
        step();
        rst = 1'b0;
        step();
        check("arst_valid", 32'(out_valid), 0);
        beat(9, 1'b1);
        check("post_total", 32'(out_total), 9);
        check("post_words", 32'(out_words), 1);

        // reset while holding a result
        #2 rst = 1'b1;
        #1;
        check("done_rst_valid", 32'(out_valid), 0);
        step();
        rst = 1'b0;
        step();
        check("done_rel_valid", 32'(out_valid), 0);
        check("done_rel_ready", 32'(in_ready), 1);

`ifdef ONES_ACC_THRESH_EN
        frame(32, 63, 1'b1);
        check("above32_total", 32'(out_total), 2016);
        check("above32", 32'(out_above), 1);
        drain();
        check("above_idle", 32'(out_above), 0);
        frame(31, 63, 1'b1);
        check("above31_total", 32'(out_total), 1953);
        check("above31", 32'(out_above), 0);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ones_accumulator

`default_nettype wire
